// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up in a final cycle and a valid/ready response.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   mag1_q, mag2_q;
  logic              neg_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   result_q;
  logic              req_ready_q, resp_valid_q, busy_q;

  logic              sign1, sign2, neg_d, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0]   abs1, abs2, special_res, fix_res, quo, rem;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_neg;

  always_comb begin
    is_div   = funct3[2];
    sign1    = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                funct3 == 3'b100 || funct3 == 3'b110) && operand1[XLEN-1];
    sign2    = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 ||
                funct3 == 3'b110) && operand2[XLEN-1];
    abs1     = sign1 ? (ONES - operand1 + 1'b1) : operand1;
    abs2     = sign2 ? (ONES - operand2 + 1'b1) : operand2;
    // Remainder takes the dividend's sign; everything else the product of the signs.
    neg_d    = (funct3 == 3'b110) ? sign1 : (sign1 ^ sign2);
    div_zero = is_div && (operand2 == '0);
    div_ovf  = is_div && !funct3[0] && (operand1 == MIN_NEG) && (operand2 == ONES);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = funct3[1] ? operand1 : ONES;
    else          special_res = funct3[1] ? '0 : operand1;

    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mag1_q : '0)};
    mul_next = {mul_sum, prod_q[XLEN-1:1]};

    // Upper half holds the partial remainder, lower half shifts the dividend out and the quotient in.
    rem_sh   = prod_q[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, mag2_q};
    div_next = {(diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]),
                prod_q[XLEN-2:0], ~diff[XLEN]};

    prod_neg = neg_q ? ('0 - prod_q) : prod_q;
    quo      = prod_q[XLEN-1:0];
    rem      = prod_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         fix_res = prod_neg[XLEN-1:0];
      3'b100, 3'b101: fix_res = neg_q ? ('0 - quo) : quo;
      3'b110, 3'b111: fix_res = neg_q ? ('0 - rem) : rem;
      default:        fix_res = prod_neg[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      mag1_q       <= '0;
      mag2_q       <= '0;
      neg_q        <= 1'b0;
      cnt_q        <= '0;
      prod_q       <= '0;
      result_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= funct3;
            mag1_q      <= abs1;
            mag2_q      <= abs2;
            neg_q       <= neg_d;
            cnt_q       <= '0;
            prod_q      <= is_div ? {{XLEN{1'b0}}, abs1} : {{XLEN{1'b0}}, abs2};
            req_ready_q <= 1'b0;
            if (special) begin
              state_q      <= DONE;
              result_q     <= special_res;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          prod_q <= op_q[2] ? div_next : mul_next;
          if (cnt_q == LAST) state_q <= FIX;
          else               cnt_q   <= cnt_q + 1'b1;
        end
        FIX: begin
          result_q     <= fix_res;
          state_q      <= DONE;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b1;
        end
        DONE: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign result     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, backpressure and reset abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .operand1   (operand1),
    .operand2   (operand2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Issue one op; lat counts edges from the accept edge (=1) until resp_valid is seen.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    funct3 = f3; operand1 = a; operand2 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    $display("op f3=%0d a=%h b=%h -> result=%h latency=%0d", f3, a, b, res, lat);
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat;
    @(negedge clk);
    funct3 = 3'b000; operand1 = 32'd7; operand2 = 32'hFFFFFFFD; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy got=%b exp=1", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mul_req_ready got=%b exp=0", req_ready); end
    lat = 1;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = result;
    $display("op MUL -> result=%h latency=%0d", r, lat);
    checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got=%0d exp=34", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_done got=%b exp=0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat;
    do_op(3'b001, 32'h80000000, 32'h80000000, r, lat);
    checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL mulh got=%h exp=40000000", r); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL mulh_latency got=%0d exp=34", lat); end
    do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu got=%h exp=fffffffe", r); end
    do_op(3'b010, 32'hFFFFFFFF, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat;
    do_op(3'b100, 32'hFFFFFFF9, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div got=%h exp=fffffffd", r); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got=%0d exp=34", lat); end
    do_op(3'b110, 32'hFFFFFFF9, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem got=%h exp=ffffffff", r); end
    do_op(3'b101, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu got=%h exp=0000000e", r); end
    do_op(3'b111, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu got=%h exp=00000002", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat;
    do_op(3'b100, 32'h12345678, 32'h0, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by_zero got=%h exp=ffffffff", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_by_zero_latency got=%0d exp=1", lat); end
    do_op(3'b111, 32'd5, 32'h0, r, lat);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu_by_zero got=%h exp=00000005", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL remu_by_zero_latency got=%0d exp=1", lat); end
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL div_ovf got=%h exp=80000000", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency got=%0d exp=1", lat); end
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL rem_ovf_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; int lat;
    resp_ready = 1'b0;
    do_op(3'b101, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL bp_result got=%h exp=0000000e", r); end
    @(negedge clk);
    funct3 = 3'b000; operand1 = 32'd3; operand2 = 32'd3; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_valid cycle=%0d got=%b exp=1", i, resp_valid); end
      checks++; if (result !== 32'd14) begin errors++; $display("FAIL bp_result_stable cycle=%0d got=%h exp=0000000e", i, result); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cycle=%0d got=%b exp=0", i, req_ready); end
    end
    $display("backpressure held 10 cycles result=%h", result);
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r; int lat;
    @(negedge clk);
    funct3 = 3'b101; operand1 = 32'd1000; operand2 = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-DIVU: req_ready=%b resp_valid=%b busy=%b result=%h",
             req_ready, resp_valid, busy, result);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'b101, 32'd1000, 32'd3, r, lat);
    checks++; if (r !== 32'd333) begin errors++; $display("FAIL after_reset_divu got=%h exp=0000014d", r); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL after_reset_latency got=%0d exp=34", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_backpressure();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
